// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event counter bank with a free-running cycle counter,
// per-channel wrap/saturate, sticky overflow flags, halt freeze and a
// registered one-cycle-latency readout port.
module perf_counter_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int INC_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          halt,
    input  logic                          clr,
    input  logic [NUM_CH*INC_W-1:0]       evt_inc,
    input  logic [NUM_CH-1:0]             cfg_sat,
    input  logic                          rd_req,
    input  logic [$clog2(NUM_CH+1)-1:0]   rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic                          rd_valid,
    output logic                          rd_err,
    output logic [NUM_CH-1:0]             ovf,
    output logic [1:0]                    state
);

    localparam int SEL_W = $clog2(NUM_CH+1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   cnt [NUM_CH];
    logic [CNT_W:0]     sum [NUM_CH];
    logic [CNT_W-1:0]   cyc_cnt;
    logic               in_run;
    logic               do_clear;
    logic               do_count;
    logic [CNT_W-1:0]   sel_val;
    logic               sel_err;

    assign state = st;

    // Clear/count qualification: clr beats counting, and a start that
    // coincides with halt in RUN is a freeze, not a restart.
    always_comb begin
        in_run   = (st == RUN);
        do_clear = clr | (start & ~(in_run & halt));
        do_count = in_run & ~do_clear;
    end

    // Run-state sequencing; halt only matters while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:    if (start) st <= RUN;
                RUN:     if (halt)  st <= FROZEN;
                FROZEN:  if (start) st <= RUN;
                default: st <= IDLE;
            endcase
        end
    end

    // Per-channel sums one bit wider than the counter so the carry flags overflow.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, cnt[i]} + {{(CNT_W+1-INC_W){1'b0}}, evt_inc[i*INC_W +: INC_W]};
        end
    end

    // Counter, cycle counter and sticky overflow update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            cyc_cnt <= '0;
            ovf     <= '0;
        end else if (do_clear) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            cyc_cnt <= '0;
            ovf     <= '0;
        end else if (do_count) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (sum[i][CNT_W]) begin
                    ovf[i] <= 1'b1;
                    cnt[i] <= cfg_sat[i] ? {CNT_W{1'b1}} : sum[i][CNT_W-1:0];
                end else begin
                    cnt[i] <= sum[i][CNT_W-1:0];
                end
            end
        end
    end

    // Read mux: channels, then the cycle counter at index NUM_CH, else error.
    always_comb begin
        sel_val = '0;
        sel_err = 1'b0;
        if (rd_sel == SEL_W'(NUM_CH)) begin
            sel_val = cyc_cnt;
        end else if (rd_sel > SEL_W'(NUM_CH)) begin
            sel_err = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_sel == SEL_W'(i)) sel_val = cnt[i];
            end
        end
    end

    // Registered readout; data and error hold between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_val;
                rd_err  <= sel_err;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with a behavioural model feeding a
// read scoreboard, plus constant checks on the key totals.
module tb_perf_counter_bank;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int INC_W  = 2;
    localparam int SEL_W  = $clog2(NUM_CH+1);

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic                    halt = 1'b0;
    logic                    clr = 1'b0;
    logic [NUM_CH*INC_W-1:0] evt_inc = '0;
    logic [NUM_CH-1:0]       cfg_sat = '0;
    logic                    rd_req = 1'b0;
    logic [SEL_W-1:0]        rd_sel = '0;
    logic [CNT_W-1:0]        rd_data;
    logic                    rd_valid;
    logic                    rd_err;
    logic [NUM_CH-1:0]       ovf;
    logic [1:0]              state;

    int n_cmp = 0;
    int n_err = 0;

    logic [CNT_W-1:0]  m_cnt [NUM_CH];
    logic [CNT_W-1:0]  m_cyc;
    logic [NUM_CH-1:0] m_ovf;
    logic [1:0]        m_state;

    typedef struct packed {
        logic [CNT_W-1:0] data;
        logic             err;
    } rd_exp_t;
    rd_exp_t sb[$];

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INC_W(INC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr),
        .evt_inc(evt_inc), .cfg_sat(cfg_sat), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .ovf(ovf), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
        m_cyc   = '0;
        m_ovf   = '0;
        m_state = 2'b00;
    endtask

    task automatic set_inc(input int ch, input logic [INC_W-1:0] v);
        evt_inc[ch*INC_W +: INC_W] = v;
    endtask

    // One clock: push expected read, advance model, then check DUT after the edge.
    task automatic cycle();
        logic           pushed;
        logic           run;
        logic           dclr;
        logic [CNT_W:0] s;
        rd_exp_t        e;
        rd_exp_t        got;
        int             idx;
        pushed = rd_req;
        if (rd_req) begin
            idx = int'(rd_sel);
            if (idx == NUM_CH) begin
                e.data = m_cyc; e.err = 1'b0;
            end else if (idx > NUM_CH) begin
                e.data = '0; e.err = 1'b1;
            end else begin
                e.data = m_cnt[idx]; e.err = 1'b0;
            end
            sb.push_back(e);
        end
        run  = (m_state == 2'b01);
        dclr = clr || (start && !(run && halt));
        if (dclr) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
            m_cyc = '0;
            m_ovf = '0;
        end else if (run) begin
            m_cyc = m_cyc + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                s = {1'b0, m_cnt[i]} + (CNT_W+1)'(evt_inc[i*INC_W +: INC_W]);
                if (s[CNT_W]) begin
                    m_ovf[i] = 1'b1;
                    m_cnt[i] = cfg_sat[i] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
                end else begin
                    m_cnt[i] = s[CNT_W-1:0];
                end
            end
        end
        if (run && halt) m_state = 2'b10;
        else if (start)  m_state = 2'b01;
        @(posedge clk); #1;
        chk("rd_valid", 64'(rd_valid), 64'(pushed));
        if (pushed) begin
            got = sb.pop_front();
            chk("rd_data", 64'(rd_data), 64'(got.data));
            chk("rd_err", 64'(rd_err), 64'(got.err));
        end
        chk("state", 64'(state), 64'(m_state));
        chk("ovf", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic rd(input int s);
        rd_req = 1'b1;
        rd_sel = SEL_W'(s);
        cycle();
        rd_req = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_err", 64'(rd_err), 64'd0);
        rst = 1'b1;

        // halt while idle is ignored
        halt = 1'b1; cycle(); halt = 1'b0;
        chk("halt_in_idle", 64'(state), 64'd0);

        // ten counted cycles, halt on the tenth
        start = 1'b1; cycle(); start = 1'b0;
        set_inc(0, 2'd1);
        for (int k = 0; k < 10; k++) begin
            halt = (k == 9);
            cycle();
        end
        halt = 1'b0;
        set_inc(0, 2'd0);
        chk("frozen_state", 64'(state), 64'd2);
        rd(0);      chk("ch0_10", 64'(rd_data), 64'd10);
        rd(NUM_CH); chk("cyc_10", 64'(rd_data), 64'd10);
        set_inc(0, 2'd1);
        repeat (3) cycle();
        set_inc(0, 2'd0);
        rd(0);      chk("ch0_frozen", 64'(rd_data), 64'd10);
        rd(NUM_CH); chk("cyc_frozen", 64'(rd_data), 64'd10);

        // saturate vs wrap on 8-bit counters
        cfg_sat = 8'b0000_0010;
        start = 1'b1; cycle(); start = 1'b0;
        set_inc(1, 2'd3); set_inc(2, 2'd3);
        repeat (86) cycle();
        set_inc(1, 2'd0); set_inc(2, 2'd0);
        chk("ovf_sat_wrap", 64'(ovf), 64'h06);
        rd(1); chk("ch1_sat", 64'(rd_data), 64'hFF);
        rd(2); chk("ch2_wrap", 64'(rd_data), 64'h02);

        // clr during counting wins over the increment
        set_inc(0, 2'd2);
        repeat (20) cycle();
        set_inc(0, 2'd0);
        rd(0); chk("ch0_40", 64'(rd_data), 64'd40);
        set_inc(0, 2'd2);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_state", 64'(state), 64'd1);
        rd(0); chk("ch0_after_clr", 64'(rd_data), 64'd0);
        set_inc(0, 2'd0);
        rd(0); chk("ch0_resumed", 64'(rd_data), 64'd2);

        // read in the same cycle as an increment returns the old value
        set_inc(3, 2'd1);
        repeat (5) cycle();
        rd(3); chk("ch3_pre", 64'(rd_data), 64'd5);
        set_inc(3, 2'd0);
        rd(3); chk("ch3_post", 64'(rd_data), 64'd6);

        // out-of-range select
        rd(NUM_CH+1);
        chk("oor_data", 64'(rd_data), 64'd0);
        chk("oor_err", 64'(rd_err), 64'd1);
        rd(15);
        chk("oor15_err", 64'(rd_err), 64'd1);

        // start together with halt in RUN freezes and keeps counts
        set_inc(0, 2'd1);
        start = 1'b1; halt = 1'b1; cycle(); start = 1'b0; halt = 1'b0;
        set_inc(0, 2'd0);
        chk("start_halt_state", 64'(state), 64'd2);
        rd(0); chk("start_halt_ch0", 64'(rd_data), 64'd3);
        rd(NUM_CH);

        // restart from FROZEN clears
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_state", 64'(state), 64'd1);
        rd(0); chk("restart_ch0", 64'(rd_data), 64'd0);

        // asynchronous reset mid-run
        set_inc(0, 2'd1);
        repeat (4) cycle();
        set_inc(0, 2'd0);
        rd(NUM_CH); chk("cyc_before_rst", 64'(rd_data), 64'd5);
        rst = 1'b0;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_rd_data", 64'(rd_data), 64'd0);
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        chk("arst_rd_err", 64'(rd_err), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rd(0); chk("post_rst_ch0", 64'(rd_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
